// File: rtl/rr_arbiter_4_to_1_if.sv
// Bundle between the 4-to-1 adapter, the round-robin arbiter and the single-lane consumer.
// master drives lane data/requests and downstream ready; slave is the arbiter.
interface rr_arbiter_4_to_1_if #(
  parameter int DATA_WIDTH = 16,
  parameter int N_INPUTS   = 4
);
  logic [N_INPUTS*DATA_WIDTH-1:0] r;
  logic [N_INPUTS-1:0]            req;
  logic [N_INPUTS-1:0]            ack;
  logic [N_INPUTS-1:0]            grant;
  logic [DATA_WIDTH-1:0]          out_data;
  logic [1:0]                     out_lane;
  logic                           out_valid;
  logic                           out_ready;
  logic                           dbg_state;

  modport master (
    output r, req, out_ready,
    input  ack, grant, out_data, out_lane, out_valid, dbg_state
  );

  modport slave (
    input  r, req, out_ready,
    output ack, grant, out_data, out_lane, out_valid, dbg_state
  );
endinterface

// File: rtl/rr_arbiter_4_to_1.sv
// Round-robin 4-lane arbiter with bounded bursts, feeding one registered output word.
// Handshake: a word moves whenever valid & ready at a rising edge (req/ack on the lane side, out_valid/out_ready downstream).
module rr_arbiter_4_to_1 #(
  parameter int DATA_WIDTH = 16,
  parameter int N_INPUTS   = 4,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  rr_arbiter_4_to_1_if.slave    bus
);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t                r_state, w_state_nxt;
  logic [1:0]            r_owner, w_owner_nxt;
  logic [1:0]            r_ptr, w_ptr_nxt;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [1:0]            r_out_lane;
  logic                  r_out_valid;

  logic                  w_space;
  logic                  w_ack_any;
  logic                  w_last;
  logic                  w_found;
  logic [1:0]            w_winner;
  logic [DATA_WIDTH-1:0] w_owner_word;

  assign w_space      = !r_out_valid || bus.out_ready;
  assign w_ack_any    = (r_state == S_GRANT) && bus.req[r_owner] && w_space;
  assign w_last       = (r_cnt + CW'(1)) == CW'(BURST);
  assign w_owner_word = bus.r[r_owner*DATA_WIDTH +: DATA_WIDTH];

  // First requesting lane scanning from the priority pointer, wrapping mod 4.
  always_comb begin
    logic [1:0] idx;
    w_found  = 1'b0;
    w_winner = r_ptr;
    idx      = r_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!w_found && bus.req[idx]) begin
        w_found  = 1'b1;
        w_winner = idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_owner_nxt = w_winner;
          w_cnt_nxt   = '0;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (!bus.req[r_owner]) begin
          w_state_nxt = S_IDLE;
          w_ptr_nxt   = r_owner + 2'd1;
        end else if (w_ack_any) begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_last) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = r_owner + 2'd1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_owner <= 2'd0;
      r_ptr   <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output stage reloads on the same edge it is drained, so back-to-back words leave no bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_lane  <= 2'd0;
      r_out_valid <= 1'b0;
    end else if (w_ack_any) begin
      r_out_data  <= w_owner_word;
      r_out_lane  <= r_owner;
      r_out_valid <= 1'b1;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.ack       = w_ack_any ? (N_INPUTS'(1) << r_owner) : '0;
  assign bus.grant     = (r_state == S_GRANT) ? (N_INPUTS'(1) << r_owner) : '0;
  assign bus.out_data  = r_out_data;
  assign bus.out_lane  = r_out_lane;
  assign bus.out_valid = r_out_valid;
  assign bus.dbg_state = (r_state == S_GRANT);
endmodule

// File: tb/tb_rr_arbiter_4_to_1.sv
// Bench for rr_arbiter_4_to_1: a BURST=4 instance checked every cycle against a lane-level reference,
// plus a BURST=1 instance for strict rotation.
module tb_rr_arbiter_4_to_1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rr_arbiter_4_to_1_if #(.DATA_WIDTH(16), .N_INPUTS(4)) if4 ();
  rr_arbiter_4_to_1_if #(.DATA_WIDTH(16), .N_INPUTS(4)) if1 ();

  rr_arbiter_4_to_1 #(.DATA_WIDTH(16), .N_INPUTS(4), .BURST(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
  rr_arbiter_4_to_1 #(.DATA_WIDTH(16), .N_INPUTS(4), .BURST(1)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int n_tests = 0;
  int n_fail  = 0;
  logic [1:0] obs_q[$];
  logic [1:0] exp_q[$];

  // Reference for the BURST=4 instance: owner -1 means nobody holds the grant.
  localparam int M_BURST = 4;
  int         m_owner, m_cnt, m_ptr, m_ol;
  bit         m_ov;
  logic [15:0] m_od;

  typedef struct {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  grant;
    logic [3:0]  ack;
    logic        valid;
    logic [1:0]  lane;
    logic [15:0] data;
  } vec_t;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lane_word(input logic [63:0] bus_r, input int k);
    logic [63:0] v;
    v = bus_r >> (16 * k);
    return v[15:0];
  endfunction

  task automatic model_reset();
    m_owner = -1; m_cnt = 0; m_ptr = 0; m_ov = 0; m_od = 16'h0; m_ol = 0;
  endtask

  function automatic logic [3:0] model_ack();
    bit space;
    space = !m_ov || if4.out_ready;
    if (m_owner >= 0 && if4.req[m_owner] && space) return 4'(1 << m_owner);
    return 4'h0;
  endfunction

  task automatic model_check();
    chk("ack", 32'(if4.ack), 32'(model_ack()));
    chk("grant", 32'(if4.grant), (m_owner < 0) ? 32'h0 : 32'(1 << m_owner));
    chk("out_valid", 32'(if4.out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("out_lane", 32'(if4.out_lane), 32'(m_ol));
      chk("out_data", 32'(if4.out_data), 32'(m_od));
    end
  endtask

  task automatic model_step();
    logic [3:0] a;
    int own;
    a = model_ack();
    own = m_owner;
    if (a != 4'h0) begin
      m_od = lane_word(if4.r, own);
      m_ol = own;
      m_ov = 1;
      m_cnt++;
      if (m_cnt == M_BURST) begin
        m_owner = -1;
        m_ptr = (own + 1) % 4;
      end
    end else begin
      if (if4.out_ready) m_ov = 0;
      if (own >= 0 && !if4.req[own]) begin
        m_owner = -1;
        m_ptr = (own + 1) % 4;
      end
      if (own < 0 && if4.req != 4'h0) begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && if4.req[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
        end
        m_cnt = 0;
      end
    end
  endtask

  // Called #1 after a falling edge with inputs already applied; ends on the next falling edge.
  task automatic tick();
    model_check();
    if (!reset) begin
      if (if4.out_valid && if4.out_ready) obs_q.push_back(if4.out_lane);
      model_step();
    end
    @(negedge clk);
  endtask

  task automatic cyc();
    #1;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if4.req = 4'h0; if4.out_ready = 1'b1; if4.r = '0;
    if1.req = 4'h0; if1.out_ready = 1'b1; if1.r = '0;
    model_reset();
    cyc();
    cyc();
    reset = 1'b0;
    obs_q.delete();
  endtask

  initial begin
    logic [15:0] d_c1;
    logic [3:0]  rq;
    int n0;

    tbl[0] = '{4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b0, 2'd0, 16'h0000};
    tbl[1] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0, 16'h0000};
    tbl[2] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 16'h89AB};
    tbl[3] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 16'h89AB};
    tbl[4] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 16'h89AB};
    tbl[5] = '{4'b0100, 1'b1, 4'b0000, 4'b0000, 1'b1, 2'd2, 16'h89AB};
    tbl[6] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 2'd0, 16'h0000};
    tbl[7] = '{4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 2'd2, 16'h89AB};

    if4.req = 4'h0; if4.out_ready = 1'b1; if4.r = '0;
    if1.req = 4'h0; if1.out_ready = 1'b1; if1.r = '0;
    @(negedge clk);
    do_reset();

    // Reset state
    #1;
    chk("rst_grant", 32'(if4.grant), 32'h0);
    chk("rst_valid", 32'(if4.out_valid), 32'h0);
    chk("rst_data", 32'(if4.out_data), 32'h0);
    chk("rst_lane", 32'(if4.out_lane), 32'h0);
    tick();

    // Single lane burst, table-driven
    for (int i = 0; i < 8; i++) begin
      if4.req = tbl[i].req;
      if4.out_ready = tbl[i].rdy;
      if4.r = {16'h7777, 16'h89AB, 16'h5555, 16'h1111};
      #1;
      chk($sformatf("tbl%0d_grant", i), 32'(if4.grant), 32'(tbl[i].grant));
      chk($sformatf("tbl%0d_ack", i), 32'(if4.ack), 32'(tbl[i].ack));
      chk($sformatf("tbl%0d_valid", i), 32'(if4.out_valid), 32'(tbl[i].valid));
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_lane", i), 32'(if4.out_lane), 32'(tbl[i].lane));
        chk($sformatf("tbl%0d_data", i), 32'(if4.out_data), 32'(tbl[i].data));
      end
      tick();
    end

    // Strict rotation on the BURST=1 instance
    do_reset();
    if1.req = 4'b1111;
    if1.r = {16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    for (int c = 0; c <= 10; c++) begin
      #1;
      chk($sformatf("rot%0d_valid", c), 32'(if1.out_valid), (c >= 2 && c % 2 == 0) ? 32'h1 : 32'h0);
      if (c >= 2 && c % 2 == 0) begin
        chk($sformatf("rot%0d_lane", c), 32'(if1.out_lane), 32'((c / 2 - 1) % 4));
        chk($sformatf("rot%0d_data", c), 32'(if1.out_data), 32'(lane_word(if1.r, (c / 2 - 1) % 4)));
      end
      if (c % 2 == 1) chk($sformatf("rot%0d_grant", c), 32'(if1.grant), 32'(1 << (((c - 1) / 2) % 4)));
      tick();
    end
    if1.req = 4'h0;

    // Burst fairness between lanes 0 and 3
    do_reset();
    if4.req = 4'b1001;
    exp_q = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
    for (int c = 0; c < 16; c++) begin
      if4.r = {16'(c), 16'hBBBB, 16'hCCCC, 16'(c + 16'hA000)};
      cyc();
    end
    chk("fair_count", 32'(obs_q.size() >= exp_q.size()), 32'h1);
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("fair_lane%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));

    // Backpressure on lane 1
    do_reset();
    if4.req = 4'b0010;
    d_c1 = 16'h0;
    for (int c = 0; c < 14; c++) begin
      if4.r = {16'hDDDD, 16'hEEEE, 16'($urandom_range(0, 65535)), 16'hFFFF};
      if (c == 1) d_c1 = if4.r[31:16];
      if4.out_ready = !(c >= 2 && c <= 4);
      if (c == 8) if4.req = 4'b0000;
      #1;
      if (c >= 2 && c <= 4) begin
        chk($sformatf("bp%0d_ack", c), 32'(if4.ack), 32'h0);
        chk($sformatf("bp%0d_hold", c), 32'(if4.out_data), 32'(d_c1));
        chk($sformatf("bp%0d_valid", c), 32'(if4.out_valid), 32'h1);
      end
      if (c == 6) chk("bp_reload_valid", 32'(if4.out_valid), 32'h1);
      tick();
    end
    chk("bp_words", 32'(obs_q.size()), 32'(M_BURST));

    // Early release: lane 0 drops after two words while lane 2 waits
    do_reset();
    if4.req = 4'b0101;
    for (int c = 0; c < 14; c++) begin
      if (c == 3) if4.req = 4'b0100;
      if (c == 11) if4.req = 4'b0000;
      if4.r = {16'h3333, 16'(16'h2000 + c), 16'h1111, 16'(c)};
      cyc();
    end
    n0 = 0;
    foreach (obs_q[i]) if (obs_q[i] == 2'd0) n0++;
    chk("early_lane0_words", 32'(n0), 32'd2);
    chk("early_next_lane", (obs_q.size() > 2) ? 32'(obs_q[2]) : 32'hFFFF, 32'd2);

    // Asynchronous reset while a word is held, then arbitration restarts at lane 0
    do_reset();
    if4.req = 4'b0010;
    if4.r = {16'h0, 16'h0, 16'h5A5A, 16'h0};
    cyc();
    cyc();
    #1;
    chk("pre_rst_valid", 32'(if4.out_valid), 32'h1);
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(if4.out_valid), 32'h0);
    chk("arst_grant", 32'(if4.grant), 32'h0);
    chk("arst_data", 32'(if4.out_data), 32'h0);
    chk("arst_lane", 32'(if4.out_lane), 32'h0);
    model_reset();
    tick();
    reset = 1'b0;
    if4.req = 4'b0110;
    cyc();
    #1;
    chk("post_rst_grant", 32'(if4.grant), 32'b0010);
    tick();

    // Randomized traffic against the reference
    rq = 4'h0;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) if ($urandom_range(0, 7) == 0) rq[k] = ~rq[k];
      if4.req = rq;
      if4.r = {16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
      if4.out_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
